sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 3125, clk_25MHZ cycles per sample period (8 kHz).
REQ-002 Parameter ADDR_W, default 13, sample ROM address width.
REQ-003 Parameters CHOMP_BASE/CHOMP_LEN, default 0/5736, GHOST_BASE/GHOST_LEN, default 5736/1024, DEATH_BASE/DEATH_LEN, default 6760/1432; ROM start address and sample count per sound.
REQ-004 clk_25MHZ  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  single-cycle sound request strobe.
REQ-007 req_sound  input  sound_t  requested sound (SOUND_NONE, SOUND_CHOMP, SOUND_GHOST, SOUND_DEATH); sampled when req_valid=1.
REQ-008 rom_addr  output  ADDR_W  address to synchronous sample ROM (1-cycle read latency).
REQ-009 rom_data  input  8  ROM read data, valid one cycle after rom_addr.
REQ-010 sample_out  output  8  unsigned sample for the PWM stage; 8'h80 = silence.
REQ-011 sample_strobe  output  1  one-cycle pulse when sample_out updates.
REQ-012 playing  output  1  high while a sound is active.
REQ-013 cur_sound  output  sound_t  sound being played; SOUND_NONE when idle.
REQ-014 done  output  1  one-cycle pulse when a sound completes naturally.
REQ-015 req_dropped  output  1  one-cycle pulse when a request is rejected.

Function
REQ-016 Tick counter SHALL count 0..CLK_DIV-1 and wrap, free-running in all states; tick=1 in the cycle count==CLK_DIV-1.
REQ-017 States SHALL be IDLE and PLAY; sample offset counter SHALL be ADDR_W bits.
REQ-018 Priority SHALL be DEATH > GHOST > CHOMP.
REQ-019 IDLE + req_valid with sound!=SOUND_NONE: next cycle PLAY, cur_sound=req_sound, offset=0, rom_addr=BASE.
REQ-020 PLAY + req_valid with priority >= cur_sound: restart at new BASE, offset=0 (preempt/retrigger); no done pulse.
REQ-021 PLAY + req_valid with lower priority: ignored, req_dropped pulses next cycle.
REQ-022 req_valid with SOUND_NONE: abort to IDLE next cycle, sample_out=8'h80, sample_strobe pulses, no done; in IDLE it is a no-op.
REQ-023 rom_addr SHALL always equal BASE(cur_sound)+offset in PLAY; hold last value in IDLE.
REQ-024 On tick in PLAY: offset < LEN-1 -> offset+1; offset == LEN-1 -> IDLE, done pulse, cur_sound=SOUND_NONE.
REQ-025 sample_out SHALL load rom_data, and sample_strobe pulse, in the cycle after every tick in PLAY (sample latched = address presented before the tick).
REQ-026 On entry to IDLE via completion, sample_out SHALL go to 8'h80 with a strobe one cycle after done.
REQ-027 Request and tick in the same cycle: request wins; offset counter not advanced.
REQ-028 playing SHALL equal (state==PLAY), registered.

Reset
REQ-029 rst=1 SHALL immediately force: IDLE, tick counter 0, offset 0, rom_addr 0, sample_out 8'h80, cur_sound SOUND_NONE, playing/sample_strobe/done/req_dropped 0.
REQ-030 rst asserted mid-playback SHALL abandon the sound with no done pulse; after release the block waits for a new request.

Verification
REQ-031 Reset, then CHOMP request -> playing=1, rom_addr=0; strobes every 3125 cycles; done after 5736 ticks; sample_out returns 8'h80.
REQ-032 CHOMP playing at offset 100, GHOST request -> rom_addr=5736 next cycle, cur_sound=SOUND_GHOST, no done.
REQ-033 DEATH playing, CHOMP request -> req_dropped pulse, rom_addr continues unchanged.
REQ-034 GHOST playing, SOUND_NONE request -> IDLE, sample_out=8'h80, done=0.
REQ-035 Request coincident with tick at offset LEN-1 -> restart at new BASE, no done pulse.
REQ-036 rst pulsed mid-DEATH -> all outputs at reset values asynchronously; no activity until next request.

Source files
------------

// File: rtl/sound_sequencer_pkg.sv
// Shared sound identifiers for the sound sequencer and its bus.
package sound_sequencer_pkg;

    typedef enum logic [1:0] {
        SOUND_NONE  = 2'd0,
        SOUND_CHOMP = 2'd1,
        SOUND_GHOST = 2'd2,
        SOUND_DEATH = 2'd3
    } sound_t;

endpackage

// File: rtl/sound_sequencer_if.sv
// Request, sample-ROM and sample-output signals of the sound sequencer.
interface sound_sequencer_if #(
    parameter int unsigned ADDR_W = 13
) ();
    import sound_sequencer_pkg::*;

    logic              req_valid;
    sound_t            req_sound;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        sample_out;
    logic              sample_strobe;
    logic              playing;
    sound_t            cur_sound;
    logic              done;
    logic              req_dropped;

    modport master (
        output req_valid, req_sound, rom_data,
        input  rom_addr, sample_out, sample_strobe, playing, cur_sound, done, req_dropped
    );

    modport slave (
        input  req_valid, req_sound, rom_data,
        output rom_addr, sample_out, sample_strobe, playing, cur_sound, done, req_dropped
    );

endinterface

// File: rtl/sound_sequencer.sv
// Plays prioritised sound clips from a sample ROM at one sample per CLK_DIV clocks.
module sound_sequencer
    import sound_sequencer_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 3125,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned CHOMP_BASE = 0,
    parameter int unsigned CHOMP_LEN  = 5736,
    parameter int unsigned GHOST_BASE = 5736,
    parameter int unsigned GHOST_LEN  = 1024,
    parameter int unsigned DEATH_BASE = 6760,
    parameter int unsigned DEATH_LEN  = 1432
) (
    input logic               clk_25MHZ,
    input logic               rst,
    sound_sequencer_if.slave  bus
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0]  SILENCE = 8'h80;

    typedef enum logic {ST_IDLE, ST_PLAY} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    sound_t            cur_sound_q, cur_sound_d;
    logic [7:0]        sample_q, sample_d;
    logic              strobe_q, strobe_d;
    logic              done_q, done_d;
    logic              dropped_q, dropped_d;
    logic              playing_q, playing_d;
    logic              tick;
    logic              req_abort;
    logic              req_accept;

    function automatic logic [1:0] prio_of(input sound_t s);
        case (s)
            SOUND_DEATH: prio_of = 2'd3;
            SOUND_GHOST: prio_of = 2'd2;
            SOUND_CHOMP: prio_of = 2'd1;
            default:     prio_of = 2'd0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input sound_t s);
        case (s)
            SOUND_DEATH: base_of = ADDR_W'(DEATH_BASE);
            SOUND_GHOST: base_of = ADDR_W'(GHOST_BASE);
            SOUND_CHOMP: base_of = ADDR_W'(CHOMP_BASE);
            default:     base_of = '0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] last_of(input sound_t s);
        case (s)
            SOUND_DEATH: last_of = ADDR_W'(DEATH_LEN - 1);
            SOUND_GHOST: last_of = ADDR_W'(GHOST_LEN - 1);
            SOUND_CHOMP: last_of = ADDR_W'(CHOMP_LEN - 1);
            default:     last_of = '0;
        endcase
    endfunction

    // Next-state and output decode; an accepted request overrides a coincident tick advance.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        rom_addr_d  = rom_addr_q;
        cur_sound_d = cur_sound_q;
        sample_d    = sample_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        dropped_d   = 1'b0;

        tick       = (tick_cnt_q == DIV_W'(CLK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + DIV_W'(1);
        req_abort  = bus.req_valid && (bus.req_sound == SOUND_NONE);
        req_accept = bus.req_valid && (bus.req_sound != SOUND_NONE) &&
                     (prio_of(bus.req_sound) >= prio_of(cur_sound_q));

        // Silence follows one cycle after a natural completion.
        if (done_q) begin
            sample_d = SILENCE;
            strobe_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_accept) begin
                    state_d     = ST_PLAY;
                    cur_sound_d = bus.req_sound;
                    offset_d    = '0;
                    rom_addr_d  = base_of(bus.req_sound);
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    sample_d = bus.rom_data;
                    strobe_d = 1'b1;
                end
                if (req_abort) begin
                    state_d     = ST_IDLE;
                    cur_sound_d = SOUND_NONE;
                    offset_d    = '0;
                    sample_d    = SILENCE;
                    strobe_d    = 1'b1;
                end else if (req_accept) begin
                    cur_sound_d = bus.req_sound;
                    offset_d    = '0;
                    rom_addr_d  = base_of(bus.req_sound);
                end else begin
                    dropped_d = bus.req_valid;
                    if (tick) begin
                        if (offset_q == last_of(cur_sound_q)) begin
                            state_d     = ST_IDLE;
                            cur_sound_d = SOUND_NONE;
                            offset_d    = '0;
                            done_d      = 1'b1;
                        end else begin
                            offset_d   = offset_q + ADDR_W'(1);
                            rom_addr_d = base_of(cur_sound_q) + offset_d;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        playing_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk_25MHZ or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            offset_q    <= '0;
            rom_addr_q  <= '0;
            cur_sound_q <= SOUND_NONE;
            sample_q    <= SILENCE;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            dropped_q   <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            offset_q    <= offset_d;
            rom_addr_q  <= rom_addr_d;
            cur_sound_q <= cur_sound_d;
            sample_q    <= sample_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            dropped_q   <= dropped_d;
            playing_q   <= playing_d;
        end
    end

    assign bus.rom_addr      = rom_addr_q;
    assign bus.sample_out    = sample_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.playing       = playing_q;
    assign bus.cur_sound     = cur_sound_q;
    assign bus.done          = done_q;
    assign bus.req_dropped   = dropped_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed and randomized checks of sound_sequencer against a sample-level playback model.
module tb_sound_sequencer;
    import sound_sequencer_pkg::*;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned CHOMP_BASE = 0;
    localparam int unsigned CHOMP_LEN  = 120;
    localparam int unsigned GHOST_BASE = 120;
    localparam int unsigned GHOST_LEN  = 40;
    localparam int unsigned DEATH_BASE = 160;
    localparam int unsigned DEATH_LEN  = 48;

    logic clk_25MHZ = 1'b0;
    logic rst       = 1'b1;

    sound_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    sound_sequencer #(
        .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W),
        .CHOMP_BASE(CHOMP_BASE), .CHOMP_LEN(CHOMP_LEN),
        .GHOST_BASE(GHOST_BASE), .GHOST_LEN(GHOST_LEN),
        .DEATH_BASE(DEATH_BASE), .DEATH_LEN(DEATH_LEN)
    ) dut (
        .clk_25MHZ(clk_25MHZ),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk_25MHZ = ~clk_25MHZ;

    logic [7:0] rom [0:255];
    always_ff @(posedge clk_25MHZ) bus.rom_data <= rom[bus.rom_addr];

    int checks   = 0;
    int failures = 0;

    // Model: sound tables indexed by sound code; priority is the numeric rank.
    int base_a [4];
    int len_a  [4];
    int prio_a [4];

    int     m_phase, m_pos, m_addr, m_prev_addr, m_sample;
    bit     m_playing, m_strobe, m_done, m_drop;
    sound_t m_sound;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_addr = 0; m_prev_addr = 0; m_sample = 8'h80;
        m_playing = 0; m_strobe = 0; m_done = 0; m_drop = 0; m_sound = SOUND_NONE;
    endtask

    task automatic model_step(input bit v, input sound_t s);
        bit     tk;
        int     rom_now, n_pos, n_sample;
        bit     n_playing, n_strobe, n_done, n_drop;
        sound_t n_sound;
        tk        = (m_phase == int'(CLK_DIV) - 1);
        rom_now   = int'(rom[m_prev_addr]);
        m_prev_addr = m_addr;
        n_pos = m_pos; n_sample = m_sample; n_playing = m_playing; n_sound = m_sound;
        n_strobe = 0; n_done = 0; n_drop = 0;
        if (m_done) begin n_sample = 8'h80; n_strobe = 1; end
        if (!m_playing) begin
            if (v && s != SOUND_NONE) begin n_playing = 1; n_sound = s; n_pos = 0; end
        end else begin
            if (tk) begin n_sample = rom_now; n_strobe = 1; end
            if (v && s == SOUND_NONE) begin
                n_playing = 0; n_sound = SOUND_NONE; n_sample = 8'h80; n_strobe = 1;
            end else if (v && prio_a[int'(s)] >= prio_a[int'(m_sound)]) begin
                n_sound = s; n_pos = 0;
            end else begin
                n_drop = v;
                if (tk) begin
                    if (m_pos + 1 == len_a[int'(m_sound)]) begin
                        n_playing = 0; n_sound = SOUND_NONE; n_done = 1;
                    end else n_pos = m_pos + 1;
                end
            end
        end
        m_phase = (m_phase + 1) % int'(CLK_DIV);
        m_pos = n_pos; m_sample = n_sample; m_playing = n_playing; m_sound = n_sound;
        m_strobe = n_strobe; m_done = n_done; m_drop = n_drop;
        if (m_playing) m_addr = base_a[int'(m_sound)] + m_pos;
    endtask

    task automatic check_all();
        chk("rom_addr",      32'(bus.rom_addr),      32'(m_addr));
        chk("sample_out",    32'(bus.sample_out),    32'(m_sample));
        chk("sample_strobe", 32'(bus.sample_strobe), 32'(m_strobe));
        chk("playing",       32'(bus.playing),       32'(m_playing));
        chk("cur_sound",     32'(bus.cur_sound),     32'(m_sound));
        chk("done",          32'(bus.done),          32'(m_done));
        chk("req_dropped",   32'(bus.req_dropped),   32'(m_drop));
    endtask

    task automatic step(input bit v, input sound_t s);
        bus.req_valid = v;
        bus.req_sound = s;
        model_step(v, s);
        @(posedge clk_25MHZ); #1;
        bus.req_valid = 1'b0;
        bus.req_sound = SOUND_NONE;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, SOUND_NONE);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        chk({tag, "_sample"},   32'(bus.sample_out), 32'h80);
        chk({tag, "_playing"},  32'(bus.playing), 32'd0);
        chk({tag, "_cur"},      32'(bus.cur_sound), 32'(SOUND_NONE));
        chk({tag, "_strobe"},   32'(bus.sample_strobe), 32'd0);
        chk({tag, "_done"},     32'(bus.done), 32'd0);
        chk({tag, "_dropped"},  32'(bus.req_dropped), 32'd0);
    endtask

    initial begin
        int strobes, last_strobe, bad_gaps, cyc;
        bit seen_done;
        base_a = '{0, CHOMP_BASE, GHOST_BASE, DEATH_BASE};
        len_a  = '{0, CHOMP_LEN, GHOST_LEN, DEATH_LEN};
        prio_a = '{0, 1, 2, 3};
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        bus.req_valid = 1'b0;
        bus.req_sound = SOUND_NONE;

        // Reset, then a complete CHOMP playback.
        rst = 1'b1;
        repeat (3) @(posedge clk_25MHZ);
        #1 rst = 1'b0;
        model_reset();
        check_reset_values("reset");
        check_all();

        step(1'b1, SOUND_CHOMP);
        chk("chomp_playing", 32'(bus.playing), 32'd1);
        chk("chomp_addr0",   32'(bus.rom_addr), 32'(CHOMP_BASE));
        strobes = 0; last_strobe = -1; bad_gaps = 0; seen_done = 0;
        for (cyc = 0; cyc < int'(CHOMP_LEN * CLK_DIV + 2 * CLK_DIV) && !seen_done; cyc++) begin
            step(1'b0, SOUND_NONE);
            if (bus.sample_strobe) begin
                if (last_strobe >= 0 && cyc - last_strobe != int'(CLK_DIV)) bad_gaps++;
                last_strobe = cyc;
                strobes++;
            end
            seen_done = bus.done;
        end
        chk("chomp_done_seen",   32'(seen_done), 32'd1);
        chk("chomp_strobe_cnt",  32'(strobes), 32'(CHOMP_LEN));
        chk("chomp_strobe_gaps", 32'(bad_gaps), 32'd0);
        step(1'b0, SOUND_NONE);
        chk("chomp_silence",  32'(bus.sample_out), 32'h80);
        chk("chomp_sil_strb", 32'(bus.sample_strobe), 32'd1);
        idle(3);

        // GHOST preempts CHOMP at offset 100.
        step(1'b1, SOUND_CHOMP);
        for (int i = 0; i < int'(CHOMP_LEN * CLK_DIV) && !(m_playing && m_pos == 100); i++)
            step(1'b0, SOUND_NONE);
        chk("at_offset_100", 32'(bus.rom_addr), 32'(CHOMP_BASE + 100));
        step(1'b1, SOUND_GHOST);
        chk("preempt_addr", 32'(bus.rom_addr), 32'(GHOST_BASE));
        chk("preempt_cur",  32'(bus.cur_sound), 32'(SOUND_GHOST));
        chk("preempt_done", 32'(bus.done), 32'd0);
        idle(5);

        // DEATH ignores a lower-priority CHOMP.
        step(1'b1, SOUND_DEATH);
        idle(9);
        step(1'b1, SOUND_CHOMP);
        chk("drop_pulse", 32'(bus.req_dropped), 32'd1);
        chk("drop_cur",   32'(bus.cur_sound), 32'(SOUND_DEATH));
        idle(6);

        // Abort a GHOST with SOUND_NONE, then SOUND_NONE while idle.
        step(1'b1, SOUND_NONE);
        step(1'b1, SOUND_GHOST);
        idle(7);
        step(1'b1, SOUND_NONE);
        chk("abort_playing", 32'(bus.playing), 32'd0);
        chk("abort_sample",  32'(bus.sample_out), 32'h80);
        chk("abort_strobe",  32'(bus.sample_strobe), 32'd1);
        chk("abort_done",    32'(bus.done), 32'd0);
        step(1'b1, SOUND_NONE);
        idle(3);

        // Request coincident with the final tick of GHOST.
        step(1'b1, SOUND_GHOST);
        for (int i = 0; i < int'(GHOST_LEN * CLK_DIV + CLK_DIV) &&
             !(m_playing && m_pos == int'(GHOST_LEN) - 1 && m_phase == int'(CLK_DIV) - 1); i++)
            step(1'b0, SOUND_NONE);
        chk("last_tick_reached", 32'(bus.rom_addr), 32'(GHOST_BASE + GHOST_LEN - 1));
        step(1'b1, SOUND_DEATH);
        chk("retrig_addr", 32'(bus.rom_addr), 32'(DEATH_BASE));
        chk("retrig_cur",  32'(bus.cur_sound), 32'(SOUND_DEATH));
        chk("retrig_done", 32'(bus.done), 32'd0);
        idle(4);

        // Randomized request traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 23) == 0) step(1'b1, sound_t'(2'($urandom_range(0, 3))));
            else step(1'b0, SOUND_NONE);
        end

        // Asynchronous reset in the middle of DEATH.
        step(1'b1, SOUND_DEATH);
        idle(11);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        repeat (3) @(posedge clk_25MHZ);
        #1 rst = 1'b0;
        model_reset();
        check_all();
        idle(3 * CLK_DIV + 2);
        chk("post_rst_idle", 32'(bus.playing), 32'd0);
        step(1'b1, SOUND_GHOST);
        chk("post_rst_start", 32'(bus.rom_addr), 32'(GHOST_BASE));
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
